// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit.
//   - State enumeration (4-bit, also exported on the State debug port)
//   - RV32 base opcode values recognised by the decoder
//   - Encodings for the ALUSrcA / ALUSrcB / ResultSrc / ALUOp fields
package multicycle_control_unit_pkg;

  localparam int STATE_W = 4;

  // JALR_TGT is the second cycle of JALR. The PC target is formed from rs1
  // there, after the link value has been written in the JALR cycle.
  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    UPPER    = 4'd12,
    TRAP     = 4'd13,
    JALR_TGT = 4'd14
  } state_t;

  // Opcodes (Instruction[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU A operand select
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  // ALU B operand select
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // Write-back select
  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEMDATA = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_CMP   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  // True for the two opcodes that depend on EN_JUMP.
  function automatic logic is_jump_op(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

  // True for the two opcodes that depend on EN_UPPER.
  function automatic logic is_upper_op(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bus between the control unit and the datapath/memory.
//   master : the control unit (reads Instruction/MemReady/Zero, drives controls)
//   slave  : the datapath side (drives Instruction/MemReady/Zero, reads controls)
// Signals:
//   Instruction[31:0] IR contents       MemReady  memory completes this cycle
//   Zero              ALU result == 0   MemReq/MemWrite/IorD  memory controls
//   IRWrite/PCWrite   register loads    ALUSrcA/ALUSrcB/ALUOp ALU controls
//   ResultSrc/RegWrite write-back       Illegal  sticky trap flag
//   State             debug state view
interface multicycle_control_unit_if #(
  parameter int ALUOP_W = 2
);
  import multicycle_control_unit_pkg::*;

  logic [31:0]        Instruction;
  logic               MemReady;
  logic               Zero;
  logic               MemReq;
  logic               MemWrite;
  logic               IorD;
  logic               IRWrite;
  logic               PCWrite;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         ResultSrc;
  logic               RegWrite;
  logic               Illegal;
  logic [STATE_W-1:0] State;

  modport master (
    input  Instruction, MemReady, Zero,
    output MemReq, MemWrite, IorD, IRWrite, PCWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, RegWrite, Illegal, State
  );

  modport slave (
    output Instruction, MemReady, Zero,
    input  MemReq, MemWrite, IorD, IRWrite, PCWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, RegWrite, Illegal, State
  );

endinterface

// File: rtl/multicycle_control_unit_decode.sv
// mcu_opcode_decode: purely combinational opcode classifier.
// Ports:
//   instruction[31:0] in  : IR contents (only [6:0] is examined)
//   en_jump           in  : accept JAL/JALR
//   en_upper          in  : accept LUI/AUIPC
//   next_class        out : state to enter after DECODE (TRAP when illegal)
//   legal             out : opcode is recognised and enabled
module mcu_opcode_decode
  import multicycle_control_unit_pkg::*;
(
  input  logic [31:0] instruction,
  input  logic        en_jump,
  input  logic        en_upper,
  output state_t      next_class,
  output logic        legal
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = instruction[6:0];
  assign unused_bits = ^instruction[31:7];

  always_comb begin
    next_class = TRAP;
    legal      = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: begin
        next_class = MEMADR;
        legal      = 1'b1;
      end
      OP_R: begin
        next_class = EXEC_R;
        legal      = 1'b1;
      end
      OP_I: begin
        next_class = EXEC_I;
        legal      = 1'b1;
      end
      OP_BRANCH: begin
        next_class = BRANCH;
        legal      = 1'b1;
      end
      default: begin
        // Optional groups: a disabled opcode falls through to TRAP.
        if (is_jump_op(opcode) && en_jump) begin
          next_class = (opcode == OP_JAL) ? JAL : JALR;
          legal      = 1'b1;
        end else if (is_upper_op(opcode) && en_upper) begin
          next_class = UPPER;
          legal      = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM.
// Ports:
//   clk   in : clock
//   rst_n in : asynchronous active-low reset; forces FETCH and zeroes every
//              output while held (an in-flight memory access is abandoned)
//   bus      : multicycle_control_unit_if.master (see interface header)
// Parameters:
//   EN_JUMP  : 1 = JAL/JALR executed, 0 = they trap
//   EN_UPPER : 1 = LUI/AUIPC executed, 0 = they trap
//   ALUOP_W  : ALUOp output width (>= 2, upper bits zero)
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int EN_JUMP  = 1,
  parameter int EN_UPPER = 1,
  parameter int ALUOP_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_unit_if.master  bus
);

  state_t     state_reg;
  state_t     state_next;
  state_t     dec_class;
  logic       dec_legal;

  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       reg_write;
  logic       illegal;

  mcu_opcode_decode u_decode (
    .instruction (bus.Instruction),
    .en_jump     (EN_JUMP != 0),
    .en_upper    (EN_UPPER != 0),
    .next_class  (dec_class),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and raw (pre-reset-gating) control outputs.
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    reg_write  = 1'b0;
    illegal    = 1'b0;

    case (state_reg)
      FETCH: begin
        // PC+4 is on the ALU; IR and PC load together when memory answers.
        mem_req  = 1'b1;
        src_a    = SRCA_PC;
        src_b    = SRCB_FOUR;
        alu_op   = ALUOP_ADD;
        ir_write = bus.MemReady;
        pc_write = bus.MemReady;
        if (bus.MemReady) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        // oldPC + imm lands in the ALU result register as the branch/JAL target.
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        state_next = dec_legal ? dec_class : TRAP;
      end
      MEMADR: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        // Instruction[5] separates store (0100011) from load (0000011).
        state_next = bus.Instruction[5] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (bus.MemReady) begin
          state_next = MEMWB;
        end
      end
      MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEMDATA;
        state_next = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.MemReady) begin
          state_next = FETCH;
        end
      end
      EXEC_R: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXEC_I: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        state_next = FETCH;
      end
      BRANCH: begin
        // funct3[0] (Instruction[12]) inverts the sense: BEQ takes on Zero,
        // BNE on !Zero. PC loads the DECODE-computed target.
        src_a      = SRCA_RS1;
        src_b      = SRCB_RS2;
        alu_op     = ALUOP_CMP;
        result_src = RES_ALUOUT;
        pc_write   = bus.Zero ^ bus.Instruction[12];
        state_next = FETCH;
      end
      JAL: begin
        // rd <= oldPC + 4 straight off the ALU; PC takes the target held in
        // the ALU result register since DECODE.
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        reg_write  = 1'b1;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      JALR: begin
        // Link write first; the rs1-relative target follows in JALR_TGT.
        // rs1 was latched during DECODE, so rd == rs1 is safe.
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        reg_write  = 1'b1;
        result_src = RES_ALU;
        state_next = JALR_TGT;
      end
      JALR_TGT: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      UPPER: begin
        // LUI (bit5=1) adds imm to zero; AUIPC adds it to oldPC.
        src_a      = bus.Instruction[5] ? SRCA_ZERO : SRCA_OLDPC;
        src_b      = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        state_next = ALUWB;
      end
      TRAP: begin
        illegal    = 1'b1;
        state_next = TRAP;
      end
      default: begin
        // Unused encoding: treat as a fault and park in TRAP.
        state_next = TRAP;
      end
    endcase
  end

  // While rst_n is low every output is forced to zero, so a memory access in
  // progress is dropped in the same cycle reset is asserted.
  assign bus.MemReq    = rst_n & mem_req;
  assign bus.MemWrite  = rst_n & mem_write;
  assign bus.IorD      = rst_n & iord;
  assign bus.IRWrite   = rst_n & ir_write;
  assign bus.PCWrite   = rst_n & pc_write;
  assign bus.RegWrite  = rst_n & reg_write;
  assign bus.Illegal   = rst_n & illegal;
  assign bus.ALUSrcA   = rst_n ? src_a      : 2'd0;
  assign bus.ALUSrcB   = rst_n ? src_b      : 2'd0;
  assign bus.ResultSrc = rst_n ? result_src : 2'd0;
  assign bus.ALUOp     = rst_n ? ALUOP_W'(alu_op) : '0;
  assign bus.State     = rst_n ? state_reg  : FETCH;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: each instruction is expanded into the per-cycle state
// sequence it must walk, every cycle's expected outputs are queued, and one
// negedge process compares both DUTs (default and EN_JUMP=0) against them.
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  typedef struct packed {
    state_t     st;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] result;
    logic       regwrite;
    logic       illegal;
  } exp_t;

  typedef struct {
    exp_t e;
    int   nj_mode;
  } item_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } lit_t;

  localparam int NJ_RESET = 0;  // no-jump DUT held in reset: all zero
  localparam int NJ_SAME  = 1;  // no-jump DUT must match the main expectation
  localparam int NJ_TRAP  = 2;  // no-jump DUT must sit in TRAP

  localparam logic [31:0] I_LOAD  = 32'h00012083;
  localparam logic [31:0] I_STORE = 32'h00112023;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ADDI  = 32'h00508093;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_nj;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALUOP_W(2)) ifc ();
  multicycle_control_unit_if #(.ALUOP_W(2)) ifn ();

  assign ifc.Instruction = instr;
  assign ifc.MemReady    = mem_ready;
  assign ifc.Zero        = zero;
  assign ifn.Instruction = instr;
  assign ifn.MemReady    = mem_ready;
  assign ifn.Zero        = zero;

  multicycle_control_unit #(.EN_JUMP(1), .EN_UPPER(1), .ALUOP_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  multicycle_control_unit #(.EN_JUMP(0), .EN_UPPER(1), .ALUOP_W(2)) dut_nj (
    .clk   (clk),
    .rst_n (rst_nj),
    .bus   (ifn.master)
  );

  item_t exp_q[$];
  lit_t  lit_q[$];
  int    vectors      = 0;
  int    miscompares  = 0;
  int    obs_regwrite = 0;
  int    obs_memwrite = 0;
  int    obs_illegal  = 0;
  int    cyc          = 0;
  int    nj_mode      = NJ_RESET;

  // Output table: what each state must drive, written from the state list.
  function automatic exp_t exp_of(input state_t st, input logic mr, input logic z,
                                  input logic [31:0] ins);
    exp_t e;
    e    = '0;
    e.st = st;
    case (st)
      FETCH:    begin e.mem_req = 1; e.srcb = 2; e.irwrite = mr; e.pcwrite = mr; end
      DECODE:   begin e.srca = 1; e.srcb = 1; end
      MEMADR:   begin e.srca = 2; e.srcb = 1; end
      MEMRD:    begin e.mem_req = 1; e.iord = 1; end
      MEMWB:    begin e.regwrite = 1; e.result = 1; end
      MEMWR:    begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; end
      EXEC_R:   begin e.srca = 2; e.srcb = 0; e.aluop = 2; end
      EXEC_I:   begin e.srca = 2; e.srcb = 1; e.aluop = 2; end
      ALUWB:    begin e.regwrite = 1; end
      BRANCH:   begin e.srca = 2; e.aluop = 1; e.pcwrite = z ^ ins[12]; end
      JAL:      begin e.srca = 1; e.srcb = 2; e.regwrite = 1; e.result = 2; e.pcwrite = 1; end
      JALR:     begin e.srca = 1; e.srcb = 2; e.regwrite = 1; e.result = 2; end
      JALR_TGT: begin e.srca = 2; e.srcb = 1; e.pcwrite = 1; end
      UPPER:    begin e.srca = ins[5] ? 2'd3 : 2'd1; e.srcb = 1; end
      TRAP:     begin e.illegal = 1; end
      default:  ;
    endcase
    return e;
  endfunction

  function automatic exp_t act_main();
    exp_t a;
    a.st = state_t'(ifc.State);
    a.mem_req = ifc.MemReq;   a.mem_write = ifc.MemWrite; a.iord = ifc.IorD;
    a.irwrite = ifc.IRWrite;  a.pcwrite = ifc.PCWrite;    a.srca = ifc.ALUSrcA;
    a.srcb = ifc.ALUSrcB;     a.aluop = ifc.ALUOp;        a.result = ifc.ResultSrc;
    a.regwrite = ifc.RegWrite; a.illegal = ifc.Illegal;
    return a;
  endfunction

  function automatic exp_t act_nj();
    exp_t a;
    a.st = state_t'(ifn.State);
    a.mem_req = ifn.MemReq;   a.mem_write = ifn.MemWrite; a.iord = ifn.IorD;
    a.irwrite = ifn.IRWrite;  a.pcwrite = ifn.PCWrite;    a.srca = ifn.ALUSrcA;
    a.srcb = ifn.ALUSrcB;     a.aluop = ifn.ALUOp;        a.result = ifn.ResultSrc;
    a.regwrite = ifn.RegWrite; a.illegal = ifn.Illegal;
    return a;
  endfunction

  task automatic cmp_field(input string who, input string fld, input logic [31:0] a,
                           input logic [31:0] e, inout bit bad);
    if (a !== e) begin
      $display("FAIL %s.%s at %0t: got %0d, expected %0d", who, fld, $time, a, e);
      bad = 1'b1;
    end
  endtask

  task automatic cmp_rec(input string who, input exp_t a, input exp_t e, inout bit bad);
    cmp_field(who, "State",     32'(a.st),   32'(e.st),   bad);
    cmp_field(who, "MemReq",    a.mem_req,   e.mem_req,   bad);
    cmp_field(who, "MemWrite",  a.mem_write, e.mem_write, bad);
    cmp_field(who, "IorD",      a.iord,      e.iord,      bad);
    cmp_field(who, "IRWrite",   a.irwrite,   e.irwrite,   bad);
    cmp_field(who, "PCWrite",   a.pcwrite,   e.pcwrite,   bad);
    cmp_field(who, "ALUSrcA",   a.srca,      e.srca,      bad);
    cmp_field(who, "ALUSrcB",   a.srcb,      e.srcb,      bad);
    cmp_field(who, "ALUOp",     a.aluop,     e.aluop,     bad);
    cmp_field(who, "ResultSrc", a.result,    e.result,    bad);
    cmp_field(who, "RegWrite",  a.regwrite,  e.regwrite,  bad);
    cmp_field(who, "Illegal",   a.illegal,   e.illegal,   bad);
  endtask

  // Single compare process: one queued vector per cycle, plus literal checks.
  always @(negedge clk) begin
    item_t it;
    exp_t  trap_e;
    exp_t  zero_e;
    lit_t  l;
    bit    bad;
    if (exp_q.size() != 0) begin
      it     = exp_q.pop_front();
      bad    = 1'b0;
      zero_e = '0;
      trap_e = '0;
      trap_e.st      = TRAP;
      trap_e.illegal = 1'b1;
      cmp_rec("main", act_main(), it.e, bad);
      case (it.nj_mode)
        NJ_SAME: cmp_rec("nojump", act_nj(), it.e, bad);
        NJ_TRAP: cmp_rec("nojump", act_nj(), trap_e, bad);
        default: cmp_rec("nojump", act_nj(), zero_e, bad);
      endcase
      vectors++;
      if (bad) miscompares++;
      obs_regwrite += int'(ifc.RegWrite);
      obs_memwrite += int'(ifc.MemWrite);
      obs_illegal  += int'(ifc.Illegal);
    end
    while (lit_q.size() != 0) begin
      l = lit_q.pop_front();
      vectors++;
      if (l.act != l.exp) begin
        $display("FAIL %s: got %0d, expected %0d", l.name, l.act, l.exp);
        miscompares++;
      end
    end
  end

  task automatic push_exp(input exp_t e);
    item_t it;
    it.e       = e;
    it.nj_mode = nj_mode;
    exp_q.push_back(it);
  endtask

  task automatic step(input state_t st, input logic mr);
    mem_ready = mr;
    push_exp(exp_of(st, mr, zero, instr));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle with both DUTs held in reset; MemReady high to prove no loads.
  task automatic rst_step();
    rst_n     = 1'b0;
    rst_nj    = 1'b0;
    mem_ready = 1'b1;
    nj_mode   = NJ_RESET;
    push_exp('0);
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string n, input int a, input int e);
    lit_t l;
    l.name = n;
    l.act  = a;
    l.exp  = e;
    lit_q.push_back(l);
  endtask

  // Expand one instruction into its required state walk.
  task automatic run(input logic [31:0] ins, input logic z, input int fs,
                     input int ms, input logic idle);
    instr = ins;
    zero  = z;
    cyc   = 0;
    repeat (fs) step(FETCH, 1'b0);
    step(FETCH, 1'b1);
    step(DECODE, idle);
    case (ins[6:0])
      7'b0000011: begin
        step(MEMADR, idle); repeat (ms) step(MEMRD, 1'b0);
        step(MEMRD, 1'b1);  step(MEMWB, idle);
      end
      7'b0100011: begin
        step(MEMADR, idle); repeat (ms) step(MEMWR, 1'b0);
        step(MEMWR, 1'b1);
      end
      7'b0110011: begin step(EXEC_R, idle); step(ALUWB, idle); end
      7'b0010011: begin step(EXEC_I, idle); step(ALUWB, idle); end
      7'b1100011: step(BRANCH, idle);
      7'b1101111: step(JAL, idle);
      7'b1100111: begin step(JALR, idle); step(JALR_TGT, idle); end
      7'b0110111, 7'b0010111: begin step(UPPER, idle); step(ALUWB, idle); end
      default: repeat (10) begin step(TRAP, idle); idle = ~idle; end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t pe;
    int   r0;
    int   w0;
    int   i0;
    rst_n = 1'b0; rst_nj = 1'b0; instr = '0; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1;
    rst_step();
    rst_step();
    rst_n = 1'b1;

    // Hand-computed pins on the output table.
    pe = exp_of(BRANCH, 1'b0, 1'b1, I_BEQ); lit("pin BEQ Zero=1 PCWrite", int'(pe.pcwrite), 1);
    pe = exp_of(BRANCH, 1'b0, 1'b1, I_BNE); lit("pin BNE Zero=1 PCWrite", int'(pe.pcwrite), 0);
    pe = exp_of(UPPER, 1'b0, 1'b0, I_LUI);  lit("pin LUI ALUSrcA", int'(pe.srca), 3);
    pe = exp_of(FETCH, 1'b0, 1'b0, I_LUI);  lit("pin FETCH stall IRWrite", int'(pe.irwrite), 0);

    r0 = obs_regwrite;
    run(I_LOAD, 1'b0, 0, 0, 1'b1);
    lit("load cycles", cyc, 5);
    lit("load RegWrite cycles", obs_regwrite - r0, 1);

    r0 = obs_regwrite; w0 = obs_memwrite;
    run(I_STORE, 1'b0, 0, 3, 1'b0);
    lit("store cycles", cyc, 7);
    lit("store MemWrite cycles", obs_memwrite - w0, 4);
    lit("store RegWrite cycles", obs_regwrite - r0, 0);

    run(I_ADD, 1'b1, 0, 0, 1'b0);   lit("R-type cycles", cyc, 4);
    run(I_ADDI, 1'b0, 2, 0, 1'b1);  lit("I-type cycles with 2 fetch stalls", cyc, 6);
    run(I_LUI, 1'b0, 0, 0, 1'b0);   lit("LUI cycles", cyc, 4);
    run(I_AUIPC, 1'b0, 0, 0, 1'b1); lit("AUIPC cycles", cyc, 4);
    run(I_BEQ, 1'b1, 0, 0, 1'b1);   lit("branch cycles", cyc, 3);
    run(I_BEQ, 1'b0, 0, 0, 1'b0);
    run(I_BNE, 1'b1, 0, 0, 1'b1);
    run(I_BNE, 1'b0, 0, 0, 1'b0);
    run(I_JAL, 1'b0, 0, 0, 1'b0);   lit("JAL cycles", cyc, 3);
    run(I_JALR, 1'b0, 0, 0, 1'b1);  lit("JALR cycles", cyc, 4);
    run(I_LOAD, 1'b0, 1, 2, 1'b0);  lit("load cycles with stalls", cyc, 8);

    // Reset in the middle of a stalled load read.
    instr = I_LOAD; zero = 1'b0;
    step(FETCH, 1'b1); step(DECODE, 1'b1); step(MEMADR, 1'b1); step(MEMRD, 1'b0);
    rst_step();
    rst_step();
    rst_n = 1'b1;
    r0 = obs_regwrite;
    step(FETCH, 1'b0);
    step(FETCH, 1'b0);
    lit("RegWrite after aborted load", obs_regwrite - r0, 0);
    run(I_ADD, 1'b0, 0, 0, 1'b1);

    // JAL on the EN_JUMP=0 instance must trap; the default instance executes it.
    instr = I_JAL; zero = 1'b0;
    rst_nj = 1'b1; nj_mode = NJ_SAME;
    step(FETCH, 1'b1);
    step(DECODE, 1'b1);
    nj_mode = NJ_TRAP;
    step(JAL, 1'b1);
    repeat (10) step(FETCH, 1'b0);
    rst_step();
    rst_n = 1'b1; rst_nj = 1'b1; nj_mode = NJ_SAME;
    step(FETCH, 1'b0);
    rst_nj = 1'b0; nj_mode = NJ_RESET;

    // Unknown opcode on the default instance.
    i0 = obs_illegal; r0 = obs_regwrite;
    run(I_BAD, 1'b0, 0, 0, 1'b1);
    lit("Illegal cycles in TRAP", obs_illegal - i0, 10);
    lit("RegWrite during trap", obs_regwrite - r0, 0);
    rst_step();
    rst_n = 1'b1;
    step(FETCH, 1'b0);
    run(I_ADDI, 1'b0, 0, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
